// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache and D-cache line bursts with round-robin arbitration.
// Latency: request seen in IDLE -> first beat on the memory port the next cycle; one IDLE cycle between bursts.
// Backpressure: mem_ready low holds the beat (valid, address and write data stable); the loser waits for the whole burst.
module mem_port_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int CNT_W         = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic                     d_req,
  input  logic                     i_we,
  input  logic                     d_we,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              i_wdata,
  input  logic [31:0]              d_wdata,
  output logic [LINE_ADDR_LEN-1:0] i_beat,
  output logic [LINE_ADDR_LEN-1:0] d_beat,
  output logic                     i_rvalid,
  output logic                     d_rvalid,
  output logic [31:0]              i_rdata,
  output logic [31:0]              d_rdata,
  output logic                     i_done,
  output logic                     d_done,
  output logic                     mem_valid,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic [CNT_W-1:0]         i_bursts,
  output logic [CNT_W-1:0]         d_bursts
);

  localparam int LB_W = 30 - LINE_ADDR_LEN;
  localparam logic [LINE_ADDR_LEN-1:0] BEAT_LAST = '1;

  typedef enum logic [1:0] {IDLE, BURST_I, BURST_D} state_e;

  state_e                   state_q, state_d;
  logic                     last_d_q, last_d_d;   // 1 = D held the most recent grant
  logic [LB_W-1:0]          line_q, line_d;
  logic                     we_q, we_d;
  logic [LINE_ADDR_LEN-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]         i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]         d_cnt_q, d_cnt_d;
  logic                     gnt_d;

  // Word-offset and byte bits of the request address are replaced by the beat counter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[LINE_ADDR_LEN+1:0], d_addr[LINE_ADDR_LEN+1:0]};

  assign i_bursts = i_cnt_q;
  assign d_bursts = d_cnt_q;

  // State and burst bookkeeping registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      line_q   <= '0;
      we_q     <= 1'b0;
      beat_q   <= '0;
      i_cnt_q  <= '0;
      d_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      line_q   <= line_d;
      we_q     <= we_d;
      beat_q   <= beat_d;
      i_cnt_q  <= i_cnt_d;
      d_cnt_q  <= d_cnt_d;
    end
  end

  // Arbitration, beat sequencing and routing of the memory port to the granted cache.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    line_d    = line_q;
    we_d      = we_q;
    beat_d    = beat_q;
    i_cnt_d   = i_cnt_q;
    d_cnt_d   = d_cnt_q;
    i_beat    = '0;
    d_beat    = '0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    gnt_d     = (state_q == BURST_D);

    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time gets the port.
        if (d_req && (!i_req || !last_d_q)) begin
          state_d  = BURST_D;
          line_d   = d_addr[31:LINE_ADDR_LEN+2];
          we_d     = d_we;
          beat_d   = '0;
          last_d_d = 1'b1;
        end else if (i_req) begin
          state_d  = BURST_I;
          line_d   = i_addr[31:LINE_ADDR_LEN+2];
          we_d     = i_we;
          beat_d   = '0;
          last_d_d = 1'b0;
        end
      end
      BURST_I, BURST_D: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = {line_q, beat_q, 2'b00};
        mem_wdata = gnt_d ? d_wdata : i_wdata;
        if (gnt_d) begin
          d_beat = beat_q;
          if (!we_q) begin
            d_rvalid = mem_ready;
            d_rdata  = mem_rdata;
          end
        end else begin
          i_beat = beat_q;
          if (!we_q) begin
            i_rvalid = mem_ready;
            i_rdata  = mem_rdata;
          end
        end
        // Request lines are not consulted here: a started burst always runs to completion.
        if (mem_ready) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            state_d = IDLE;
            if (gnt_d) begin
              d_done  = 1'b1;
              d_cnt_d = d_cnt_q + 1'b1;
            end else begin
              i_done  = 1'b1;
              i_cnt_d = i_cnt_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
